// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding,
// next-PC select codes and the per-stage control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MC_BUSY  = 2'b01,
    MEM_WAIT = 2'b10,
    HALT     = 2'b11
  } seq_state_e;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  // Pipeline register controls, MSB first in this order.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idexe_we;
    logic idexe_bubble;
    logic exemem_we;
    logic exemem_bubble;
    logic memwb_we;
  } stage_ctrl_t;

  // Free-running pipeline: every register loads, nothing is squashed.
  localparam stage_ctrl_t CTRL_RUN        = 8'b1101_0101;
  // Whole pipeline holds (data memory not ready).
  localparam stage_ctrl_t CTRL_FREEZE     = 8'b0000_0000;
  // PC and IF/ID hold, a NOP enters ID/EXE (load-use, halt).
  localparam stage_ctrl_t CTRL_FRONT_HOLD = 8'b0001_1101;
  // Everything up to EXE holds, a NOP enters EXE/MEM, MEM/WB drains.
  localparam stage_ctrl_t CTRL_MC_WAIT    = 8'b0000_0011;
  // Multi-cycle result (or aborted result) is captured into EXE/MEM.
  localparam stage_ctrl_t CTRL_MC_DONE    = 8'b0000_0101;

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Bundle between the sequencer and the pipeline / multi-cycle unit.
//
// Multi-cycle handshake: mc_go is a registered one-cycle pulse issued
// when a new multi-cycle op is seen in EXE. The unit answers with a
// one-cycle mc_done pulse when its result is valid. If no mc_done comes
// within MC_TIMEOUT busy cycles the sequencer issues a one-cycle
// mc_abort pulse and moves on; an op is started at most once.
interface pipe_seq_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_stall;
  logic [1:0]       id_pcsource;
  logic             id_halt;
  logic             exe_mc;
  logic             mc_done;
  logic             dmem_ready;
  logic             mem_access;
  logic             resume;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idexe_we;
  logic             idexe_bubble;
  logic             exemem_we;
  logic             exemem_bubble;
  logic             memwb_we;
  logic             mc_go;
  logic             mc_abort;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;

  // Sequencer side.
  modport master (
    input  id_stall, id_pcsource, id_halt, exe_mc, mc_done,
           dmem_ready, mem_access, resume,
    output pc_we, ifid_we, ifid_flush, idexe_we, idexe_bubble,
           exemem_we, exemem_bubble, memwb_we, mc_go, mc_abort,
           state, cnt_stall, cnt_flush
  );

  // Pipeline / multi-cycle unit side.
  modport slave (
    output id_stall, id_pcsource, id_halt, exe_mc, mc_done,
           dmem_ready, mem_access, resume,
    input  pc_we, ifid_we, ifid_flush, idexe_we, idexe_bubble,
           exemem_we, exemem_bubble, memwb_we, mc_go, mc_abort,
           state, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/pipe_seq_ctrl_mc_timeout_ctr.sv
// Counts cycles spent waiting on the multi-cycle unit. Saturates at the
// limit so a timeout masked by a memory freeze is still seen afterwards.
module mc_timeout_ctr #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(MC_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MC_TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // The current busy cycle is the MC_TIMEOUT-th one (or later).
  assign expire = en && (cnt_q >= LIMIT);

  // Next count: clear outside busy, step while busy until the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pipe_seq_ctrl.sv
// Central sequencer of the 5-stage pipeline: folds memory wait,
// multi-cycle EXE, halt, load-use and redirect into the pipeline
// register enables, drives the multi-cycle handshake and counts hazards.
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic           clk,
  input logic           rst,
  pipe_seq_ctrl_if.master bus
);
  seq_state_e       state_q, state_d;
  logic             mc_go_q, mc_go_d;
  logic             mc_abort_q, mc_abort_d;
  logic             mc_served_q, mc_served_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  stage_ctrl_t      ctrl;
  logic             mem_wait;
  logic             mc_busy;
  logic             mc_expire;

  assign mem_wait = bus.mem_access && !bus.dmem_ready;
  assign mc_busy  = (state_q == MC_BUSY);

  mc_timeout_ctr #(.MC_TIMEOUT(MC_TIMEOUT)) u_mc_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!mc_busy),
    .en     (mc_busy),
    .expire (mc_expire)
  );

  // Next state, stage controls and handshake pulses by cause priority.
  // The cycle that launches a multi-cycle op already holds the front and
  // bubbles EXE/MEM, since EXE has no result to pass on yet.
  // mc_served marks that the op still sitting in EXE has already run,
  // so it is not started again before ID/EXE loads a new instruction.
  always_comb begin
    ctrl        = CTRL_RUN;
    state_d     = state_q;
    mc_go_d     = 1'b0;
    mc_abort_d  = 1'b0;
    mc_served_d = mc_served_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
          if (bus.exe_mc && !mc_served_q) begin
            ctrl    = CTRL_MC_WAIT;
            mc_go_d = 1'b1;
            state_d = MC_BUSY;
          end else if (bus.id_halt) begin
            ctrl    = CTRL_FRONT_HOLD;
            state_d = HALT;
          end else if (bus.id_stall) begin
            ctrl = CTRL_FRONT_HOLD;
          end else if (bus.id_pcsource != PCSRC_SEQ) begin
            ctrl.ifid_flush = (DELAY_SLOT == 0);
          end
        end
      end
      MC_BUSY: begin
        if (mem_wait) begin
          ctrl = CTRL_FREEZE;
        end else if (bus.mc_done || mc_expire) begin
          ctrl        = CTRL_MC_DONE;
          mc_abort_d  = !bus.mc_done;
          mc_served_d = 1'b1;
          state_d     = RUN;
        end else begin
          ctrl = CTRL_MC_WAIT;
        end
      end
      HALT: begin
        // On resume the front advances past the halt instruction, which
        // is replaced by a bubble in ID/EXE.
        ctrl = CTRL_FRONT_HOLD;
        if (bus.resume) begin
          ctrl.pc_we   = 1'b1;
          ctrl.ifid_we = 1'b1;
          state_d      = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (ctrl.idexe_we) mc_served_d = 1'b0;
    cnt_stall_d = cnt_stall_q + {{(CNT_W-1){1'b0}}, ~ctrl.pc_we};
    cnt_flush_d = cnt_flush_q + {{(CNT_W-1){1'b0}}, ctrl.ifid_flush};
  end

  // State, pulse and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mc_go_q     <= 1'b0;
      mc_abort_q  <= 1'b0;
      mc_served_q <= 1'b0;
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_go_q     <= mc_go_d;
      mc_abort_q  <= mc_abort_d;
      mc_served_q <= mc_served_d;
      cnt_stall_q <= cnt_stall_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign bus.pc_we         = ctrl.pc_we;
  assign bus.ifid_we       = ctrl.ifid_we;
  assign bus.ifid_flush    = ctrl.ifid_flush;
  assign bus.idexe_we      = ctrl.idexe_we;
  assign bus.idexe_bubble  = ctrl.idexe_bubble;
  assign bus.exemem_we     = ctrl.exemem_we;
  assign bus.exemem_bubble = ctrl.exemem_bubble;
  assign bus.memwb_we      = ctrl.memwb_we;
  assign bus.mc_go         = mc_go_q;
  assign bus.mc_abort      = mc_abort_q;
  assign bus.state         = state_q;
  assign bus.cnt_stall     = cnt_stall_q;
  assign bus.cnt_flush     = cnt_flush_q;
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: a delay-slot and a flushing instance share
// the same stimulus; directed scenarios plus a randomized run against a
// cause-priority reference model.
module tb_pipe_seq_ctrl;
  // Control vector order: pc_we ifid_we ifid_flush idexe_we
  //                       idexe_bubble exemem_we exemem_bubble memwb_we
  localparam logic [7:0] E_RUN    = 8'b1101_0101;
  localparam logic [7:0] E_FREEZE = 8'b0000_0000;
  localparam logic [7:0] E_HOLD   = 8'b0001_1101;
  localparam logic [7:0] E_MCW    = 8'b0000_0011;
  localparam logic [7:0] E_MCD    = 8'b0000_0101;
  localparam logic [7:0] E_RESUME = 8'b1101_1101;
  localparam logic [7:0] E_FLUSH  = 8'b0010_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_seq_ctrl_if #(.CNT_W(32)) bi1 ();
  pipe_seq_ctrl_if #(.CNT_W(32)) bi0 ();

  assign bi0.id_stall    = bi1.id_stall;
  assign bi0.id_pcsource = bi1.id_pcsource;
  assign bi0.id_halt     = bi1.id_halt;
  assign bi0.exe_mc      = bi1.exe_mc;
  assign bi0.mc_done     = bi1.mc_done;
  assign bi0.dmem_ready  = bi1.dmem_ready;
  assign bi0.mem_access  = bi1.mem_access;
  assign bi0.resume      = bi1.resume;

  pipe_seq_ctrl #(.DELAY_SLOT(1), .MC_TIMEOUT(64), .CNT_W(32)) dut_ds1 (
    .clk(clk), .rst(rst), .bus(bi1.master));
  pipe_seq_ctrl #(.DELAY_SLOT(0), .MC_TIMEOUT(64), .CNT_W(32)) dut_ds0 (
    .clk(clk), .rst(rst), .bus(bi0.master));

  logic [7:0] ctl1, ctl0;
  assign ctl1 = {bi1.pc_we, bi1.ifid_we, bi1.ifid_flush, bi1.idexe_we,
                 bi1.idexe_bubble, bi1.exemem_we, bi1.exemem_bubble, bi1.memwb_we};
  assign ctl0 = {bi0.pc_we, bi0.ifid_we, bi0.ifid_flush, bi0.idexe_we,
                 bi0.idexe_bubble, bi0.exemem_we, bi0.exemem_bubble, bi0.memwb_we};

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic set_in(input logic stall, input logic [1:0] pcs, input logic halt,
                        input logic emc, input logic done, input logic macc,
                        input logic dready, input logic res);
    bi1.id_stall    = stall;
    bi1.id_pcsource = pcs;
    bi1.id_halt     = halt;
    bi1.exe_mc      = emc;
    bi1.mc_done     = done;
    bi1.mem_access  = macc;
    bi1.dmem_ready  = dready;
    bi1.resume      = res;
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle.
  task automatic drive(input logic stall, input logic [1:0] pcs, input logic halt,
                       input logic emc, input logic done, input logic macc,
                       input logic dready, input logic res);
    @(negedge clk);
    set_in(stall, pcs, halt, emc, done, macc, dready, res);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (ctl1 !== E_RUN) begin n_errors++; $display("FAIL reset_ctl_ds1: got %b expected %b", ctl1, E_RUN); end
    n_checks++; if (ctl0 !== E_RUN) begin n_errors++; $display("FAIL reset_ctl_ds0: got %b expected %b", ctl0, E_RUN); end
    n_checks++; if (bi1.state !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b expected 00", bi1.state); end
    n_checks++; if (bi1.cnt_stall !== 32'd0 || bi0.cnt_flush !== 32'd0) begin n_errors++; $display("FAIL reset_counters: got stall %0d flush %0d expected 0 0", bi1.cnt_stall, bi0.cnt_flush); end
    n_checks++; if (bi1.mc_go !== 1'b0 || bi1.mc_abort !== 1'b0) begin n_errors++; $display("FAIL reset_pulses: got go %b abort %b expected 0 0", bi1.mc_go, bi1.mc_abort); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ctl1 !== E_HOLD) begin n_errors++; $display("FAIL load_use_ctl_ds1: got %b expected %b", ctl1, E_HOLD); end
    n_checks++; if (ctl0 !== E_HOLD) begin n_errors++; $display("FAIL load_use_ctl_ds0: got %b expected %b", ctl0, E_HOLD); end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi1.cnt_stall !== 32'd1) begin n_errors++; $display("FAIL load_use_cnt_stall: got %0d expected 1", bi1.cnt_stall); end
    n_checks++; if (bi0.cnt_flush !== 32'd0) begin n_errors++; $display("FAIL load_use_cnt_flush: got %0d expected 0", bi0.cnt_flush); end
  endtask

  task automatic test_mc_done();
    do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ctl1 !== E_MCW || bi1.state !== 2'b00) begin n_errors++; $display("FAIL mc_launch: got ctl %b state %b expected %b 00", ctl1, bi1.state, E_MCW); end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (bi1.state !== 2'b01 || ctl1 !== E_MCW) begin n_errors++; $display("FAIL mc_busy_%0d: got state %b ctl %b expected 01 %b", k, bi1.state, ctl1, E_MCW); end
      n_checks++; if (bi1.mc_go !== (k == 1)) begin n_errors++; $display("FAIL mc_go_%0d: got %b expected %b", k, bi1.mc_go, (k == 1)); end
    end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ctl1 !== E_MCD || bi1.state !== 2'b01) begin n_errors++; $display("FAIL mc_done_cycle: got ctl %b state %b expected %b 01", ctl1, bi1.state, E_MCD); end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ctl1 !== E_RUN || bi1.state !== 2'b00 || bi1.mc_abort !== 1'b0) begin n_errors++; $display("FAIL mc_after_done: got ctl %b state %b abort %b expected %b 00 0", ctl1, bi1.state, bi1.mc_abort, E_RUN); end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi1.mc_go !== 1'b0 || bi1.state !== 2'b00) begin n_errors++; $display("FAIL mc_no_retrigger: got go %b state %b expected 0 00", bi1.mc_go, bi1.state); end
    n_checks++; if (bi1.cnt_stall !== 32'd7) begin n_errors++; $display("FAIL mc_cnt_stall: got %0d expected 7", bi1.cnt_stall); end
  endtask

  task automatic test_mc_timeout();
    do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (bi1.state !== 2'b01 || bi1.mc_abort !== 1'b0) begin n_errors++; $display("FAIL timeout_busy_%0d: got state %b abort %b expected 01 0", k, bi1.state, bi1.mc_abort); end
      n_checks++; if (ctl1 !== ((k == 64) ? E_MCD : E_MCW)) begin n_errors++; $display("FAIL timeout_ctl_%0d: got %b expected %b", k, ctl1, (k == 64) ? E_MCD : E_MCW); end
    end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi1.mc_abort !== 1'b1 || bi1.state !== 2'b00) begin n_errors++; $display("FAIL timeout_abort: got abort %b state %b expected 1 00", bi1.mc_abort, bi1.state); end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi1.mc_abort !== 1'b0 || bi1.mc_go !== 1'b0) begin n_errors++; $display("FAIL timeout_single_pulse: got abort %b go %b expected 0 0", bi1.mc_abort, bi1.mc_go); end
  endtask

  task automatic test_mem_in_mc();
    do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (ctl1 !== E_FREEZE || bi1.state !== 2'b01) begin n_errors++; $display("FAIL mem_in_mc_%0d: got ctl %b state %b expected %b 01", k, ctl1, bi1.state, E_FREEZE); end
    end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (ctl1 !== E_MCW || bi1.state !== 2'b01) begin n_errors++; $display("FAIL mc_resumes: got ctl %b state %b expected %b 01", ctl1, bi1.state, E_MCW); end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ctl1 !== E_MCD) begin n_errors++; $display("FAIL mc_done_after_mem: got %b expected %b", ctl1, E_MCD); end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi1.state !== 2'b00) begin n_errors++; $display("FAIL mc_mem_end_state: got %b expected 00", bi1.state); end
  endtask

  task automatic test_mem_wait_run();
    do_reset();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (ctl0 !== E_FREEZE || bi0.state !== 2'b00) begin n_errors++; $display("FAIL mem_wait_enter: got ctl %b state %b expected %b 00", ctl0, bi0.state, E_FREEZE); end
    drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (ctl0 !== E_FREEZE || bi0.state !== 2'b10) begin n_errors++; $display("FAIL mem_wait_hold: got ctl %b state %b expected %b 10", ctl0, bi0.state, E_FREEZE); end
    drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (ctl0 !== (E_RUN | E_FLUSH) || ctl1 !== E_RUN) begin n_errors++; $display("FAIL mem_wait_release: got ds0 %b ds1 %b expected %b %b", ctl0, ctl1, E_RUN | E_FLUSH, E_RUN); end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi0.state !== 2'b00 || bi0.cnt_stall !== 32'd2) begin n_errors++; $display("FAIL mem_wait_after: got state %b stall %0d expected 00 2", bi0.state, bi0.cnt_stall); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ctl0 !== (E_RUN | E_FLUSH)) begin n_errors++; $display("FAIL redirect_ds0: got %b expected %b", ctl0, E_RUN | E_FLUSH); end
    n_checks++; if (ctl1 !== E_RUN) begin n_errors++; $display("FAIL redirect_ds1: got %b expected %b", ctl1, E_RUN); end
    drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi0.cnt_flush !== 32'd1 || bi1.cnt_flush !== 32'd0) begin n_errors++; $display("FAIL redirect_cnt_1: got ds0 %0d ds1 %0d expected 1 0", bi0.cnt_flush, bi1.cnt_flush); end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi0.cnt_flush !== 32'd2 || bi0.cnt_stall !== 32'd0) begin n_errors++; $display("FAIL redirect_cnt_2: got flush %0d stall %0d expected 2 0", bi0.cnt_flush, bi0.cnt_stall); end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ctl1 !== E_HOLD || bi1.state !== 2'b00) begin n_errors++; $display("FAIL halt_enter: got ctl %b state %b expected %b 00", ctl1, bi1.state, E_HOLD); end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, (k == 2), 1'b0, (k == 4));
      n_checks++; if (bi1.state !== 2'b11) begin n_errors++; $display("FAIL halt_state_%0d: got %b expected 11", k, bi1.state); end
      n_checks++; if (ctl1 !== ((k == 4) ? E_RESUME : E_HOLD)) begin n_errors++; $display("FAIL halt_ctl_%0d: got %b expected %b", k, ctl1, (k == 4) ? E_RESUME : E_HOLD); end
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bi1.state !== 2'b00 || ctl1 !== E_RUN) begin n_errors++; $display("FAIL halt_exit: got state %b ctl %b expected 00 %b", bi1.state, ctl1, E_RUN); end
  endtask

  task automatic test_reset_mid_mc();
    do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++; if (bi1.state !== 2'b00 || ctl1 !== E_RUN || bi1.mc_go !== 1'b0) begin n_errors++; $display("FAIL reset_mid_mc: got state %b ctl %b go %b expected 00 %b 0", bi1.state, ctl1, bi1.mc_go, E_RUN); end
  endtask

  // Randomized run against a cause-priority model of the sequencer.
  task automatic test_random();
    int mode = 0;          // 0 run, 1 waiting on MC unit, 2 memory wait, 3 halted
    int busy_cycles = 0;   // MC cycles already spent
    bit op_ran = 0;        // op still in EXE has already executed
    bit exp_go = 0, exp_abort = 0;
    logic [31:0] exp_stall = 0, exp_flush = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic stall, halt, emc, done, macc, dready, res;
      logic [1:0] pcs;
      logic [7:0] exp;
      bit redir, nxt_go, nxt_abort, wait_mem;
      int nmode;
      stall  = ($urandom_range(99, 0) < 20);
      pcs    = 2'($urandom_range(3, 0));
      halt   = ($urandom_range(99, 0) < 5);
      emc    = ($urandom_range(99, 0) < 25);
      done   = ($urandom_range(99, 0) < 12);
      macc   = ($urandom_range(99, 0) < 30);
      dready = ($urandom_range(99, 0) < 55);
      res    = ($urandom_range(99, 0) < 30);
      drive(stall, pcs, halt, emc, done, macc, dready, res);
      exp = E_RUN; redir = 0; nxt_go = 0; nxt_abort = 0; nmode = mode;
      wait_mem = macc && !dready;
      if (mode == 3) begin
        exp = res ? E_RESUME : E_HOLD;
        if (res) nmode = 0;
      end else if (wait_mem) begin
        exp = E_FREEZE;
        if (mode != 1) nmode = 2;
      end else if (mode == 1) begin
        if (done || busy_cycles + 1 >= 64) begin
          exp = E_MCD; nmode = 0; nxt_abort = !done;
        end else begin
          exp = E_MCW;
        end
      end else begin
        nmode = 0;
        if (emc && !op_ran) begin exp = E_MCW; nxt_go = 1; nmode = 1; end
        else if (halt) begin exp = E_HOLD; nmode = 3; end
        else if (stall) exp = E_HOLD;
        else if (pcs != 2'b00) redir = 1;
      end
      n_checks++; if (ctl1 !== exp) begin n_errors++; $display("FAIL rand_ctl_ds1 cyc %0d: got %b expected %b", c, ctl1, exp); end
      n_checks++; if (ctl0 !== (redir ? (exp | E_FLUSH) : exp)) begin n_errors++; $display("FAIL rand_ctl_ds0 cyc %0d: got %b expected %b", c, ctl0, redir ? (exp | E_FLUSH) : exp); end
      n_checks++; if (bi1.state !== 2'(mode) || bi0.state !== 2'(mode)) begin n_errors++; $display("FAIL rand_state cyc %0d: got %b %b expected %0d", c, bi1.state, bi0.state, mode); end
      n_checks++; if (bi1.mc_go !== exp_go || bi1.mc_abort !== exp_abort) begin n_errors++; $display("FAIL rand_pulses cyc %0d: got go %b abort %b expected %b %b", c, bi1.mc_go, bi1.mc_abort, exp_go, exp_abort); end
      n_checks++; if (bi1.cnt_stall !== exp_stall || bi0.cnt_flush !== exp_flush || bi1.cnt_flush !== 32'd0) begin n_errors++; $display("FAIL rand_counters cyc %0d: got stall %0d flush %0d/%0d expected %0d %0d/0", c, bi1.cnt_stall, bi0.cnt_flush, bi1.cnt_flush, exp_stall, exp_flush); end
      // Advance the model across the clock edge.
      if (mode == 1 && nmode == 0) op_ran = 1;
      else if (exp[4]) op_ran = 0;
      busy_cycles = (mode == 1) ? busy_cycles + 1 : 0;
      if (!exp[7]) exp_stall++;
      if (redir) exp_flush++;
      exp_go = nxt_go; exp_abort = nxt_abort; mode = nmode;
    end
  endtask

  initial begin
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_mc_done();
    test_mc_timeout();
    test_mem_in_mc();
    test_mem_wait_run();
    test_redirect();
    test_halt();
    test_reset_mid_mc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Merges stall and flush causes into one set of per-stage register write-enables and bubble/flush controls:
  - ID load-use stall
  - ID branch/jump redirect
  - multi-cycle EXE op (mul/div)
  - data-memory wait
  - halt instruction
- Owns the handshake with the multi-cycle unit and keeps hazard performance counters.
- Sits beside the IF/ID/EXE/MEM/WB pipeline registers and drives their enables.

Parameters:
- DELAY_SLOT, 1, 1 = branch delay slot (no IF/ID flush on redirect); 0 = flush IF/ID on redirect
- MC_TIMEOUT, 64, max cycles in MC_BUSY before forced abort
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_stall  in  1  load-use stall request from ID
- id_pcsource  in  2  ID next-PC select; 01 = branch taken, 10 = jump, 00 = sequential
- id_halt  in  1  halt instruction decoded in ID
- exe_mc  in  1  EXE stage holds a valid multi-cycle op
- mc_done  in  1  multi-cycle unit result valid (single-cycle pulse)
- dmem_ready  in  1  data memory completes access this cycle
- mem_access  in  1  MEM stage holds a load/store
- resume  in  1  leave HALT
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID
- idexe_we  out  1  ID/EXE write enable
- idexe_bubble  out  1  load NOP into ID/EXE (clears wreg/wmem)
- exemem_we  out  1  EXE/MEM write enable
- exemem_bubble  out  1  load NOP into EXE/MEM
- memwb_we  out  1  MEM/WB write enable
- mc_go  out  1  start pulse to multi-cycle unit
- mc_abort  out  1  abort pulse on timeout
- state  out  2  current FSM state
- cnt_stall  out  CNT_W  cycles with pc_we=0
- cnt_flush  out  CNT_W  IF/ID flushes issued

Behaviour:
- FSM states:
  - RUN=00
  - MC_BUSY=01
  - MEM_WAIT=10
  - HALT=11
- Reset (rst=1 at clk edge):
  - state=RUN, counters=0, timeout counter=0
  - mc_go=mc_abort=0
  - Combinational outputs evaluate as RUN with no requests: all *_we=1, all flush/bubble=0.
  - Reset mid-operation drops any MC/MEM wait immediately; the multi-cycle unit is reset by the same rst.
- Control values are combinational from state and inputs; state, counters and pulses are registered.
- Priority within a cycle, highest first:
  1. MEM wait
  2. MC busy
  3. halt
  4. load-use stall
  5. redirect
- MEM wait: mem_access=1 and dmem_ready=0 (in any state except HALT):
  - all *_we=0 (full freeze), no bubbles
  - From RUN, next state=MEM_WAIT.
  - In MEM_WAIT, return to RUN on the cycle dmem_ready=1; that cycle behaves as RUN.
- MC busy: in RUN with exe_mc=1 and the op not yet started:
  - assert registered mc_go for one cycle; next state=MC_BUSY
  - In MC_BUSY: pc_we=ifid_we=idexe_we=exemem_we=0, exemem_bubble=1, memwb_we=1 (older instrs drain).
  - mc_done=1 in MC_BUSY: that cycle exemem_we=1 and exemem_bubble=0 (result captured); next state=RUN. The same op must not re-trigger mc_go.
  - Timeout counter increments each MC_BUSY cycle. On reaching MC_TIMEOUT: one-cycle mc_abort, next state=RUN, EXE result captured as-is.
  - mc_done and timeout in the same cycle: mc_done wins, no abort.
- Halt: id_halt in RUN:
  - next state=HALT; pc_we=ifid_we=0, idexe_bubble=1
  - In HALT the older stages drain (exemem_we=memwb_we=1), front stays frozen.
  - resume=1 returns to RUN.
- Load-use: id_stall=1 in RUN:
  - pc_we=ifid_we=0, idexe_bubble=1; the redirect in the same cycle is ignored.
- Redirect: id_pcsource!=00 with no higher cause:
  - pc_we=1
  - ifid_flush=1 only if DELAY_SLOT=0; cnt_flush increments.
- cnt_stall increments every cycle pc_we=0; counters wrap at 2^CNT_W.

Decomposition:
- Shared package pipe_ctrl_pkg: state encodings RUN/MC_BUSY/MEM_WAIT/HALT and PCSRC_SEQ/BR/J constants (00/01/10).
- One natural sub-module: mc_timeout_ctr, holding the timeout counter with clear/enable/expire.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> all *_we=1, flush/bubble=0, state=00, counters=0.
- id_stall=1 for 1 cycle with id_pcsource=01 -> pc_we=ifid_we=0, idexe_bubble=1, ifid_flush=0; cnt_stall=1.
- exe_mc=1, mc_done after 5 busy cycles -> single mc_go pulse; state=01 for 5 cycles with exemem_bubble=1; done cycle exemem_we=1; state=00; no second mc_go.
- exe_mc=1, mc_done never, MC_TIMEOUT=64 -> mc_abort pulse after 64 busy cycles; state returns to 00.
- mem_access=1, dmem_ready=0 for 3 cycles during MC_BUSY -> all *_we=0 for those cycles; MEM priority holds; MC resumes afterward.
- DELAY_SLOT=0, id_pcsource=10 -> ifid_flush=1, cnt_flush=1. DELAY_SLOT=1 -> ifid_flush=0. id_halt, then resume after 4 cycles -> state 11 for 4 cycles, then 00.
